// File: rtl/perceptron_pkg.sv
// perceptron_pkg: shared FSM state type, class constants and the class target table
package perceptron_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, CLASSIFY, HOLD} state_e;
  localparam int NUM_CLASSES = 10;
  localparam logic [3:0] CLASS_NONE = 4'hF;
  // Class 0 lives in the least significant byte.
  localparam logic [79:0] TARGETS = {8'd26, 8'd64, 8'd4, 8'd40, 8'd28, 8'd6, 8'd34, 8'd20, 8'd2, 8'd32};
  function automatic logic [7:0] target(input logic [3:0] i);
    return TARGETS[32'(i) * 8 +: 8];
  endfunction
endpackage

// File: rtl/perceptron_match.sv
// perceptron_match: compares the accumulator with one table entry; PERCEPTRON_NEAREST_EN adds the absolute distance
module perceptron_match import perceptron_pkg::*; (
  input  logic [7:0] acc_i,
  input  logic [3:0] idx_i,
`ifdef PERCEPTRON_NEAREST_EN
  output logic [7:0] dist_o,
`endif
  output logic       hit_o
);
  logic [7:0] tgt;
  assign tgt = target(idx_i);
  assign hit_o = acc_i == tgt;
`ifdef PERCEPTRON_NEAREST_EN
  assign dist_o = acc_i >= tgt ? acc_i - tgt : tgt - acc_i;
`endif
endmodule

// File: rtl/perceptron_sequencer.sv
// perceptron_sequencer: accumulates weighted feature samples per frame and classifies the sum against a table; PERCEPTRON_NEAREST_EN selects nearest-target fallback
module perceptron_sequencer import perceptron_pkg::*; #(
  parameter int EDGE_SHIFT  = 3,
  parameter int CURVE_SHIFT = 1,
  parameter int MAX_SAMPLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_edges,
  input  logic [3:0] in_curves,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_class,
  output logic [7:0] out_sum,
  output logic       out_overrun
);
  localparam int CW = $clog2(MAX_SAMPLES + 1);
  state_e state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovr_q, ovr_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] class_q, class_d;
  logic accept, last_cnt, done, hit, in_class, last_idx;
  logic [15:0] sum;
  logic [7:0] acc_sat;
  assign accept   = in_valid & in_ready;
  assign last_cnt = cnt_q == CW'(MAX_SAMPLES - 1);
  assign done     = state_q == HOLD && out_ready;
  assign in_class = state_q == CLASSIFY;
  assign last_idx = idx_q == 4'(NUM_CLASSES - 1);
  assign sum      = 16'(acc_q) + (16'(in_edges) << EDGE_SHIFT) + (16'(in_curves) << CURVE_SHIFT);
  assign acc_sat  = sum > 16'd255 ? 8'hFF : sum[7:0];
`ifdef PERCEPTRON_NEAREST_EN
  logic [7:0] dist, best_q, best_d;
  logic upd;
  perceptron_match u_match (.acc_i(acc_q), .idx_i(idx_q), .dist_o(dist), .hit_o(hit));
  // An exact hit has distance 0, so strict-less keeps the lowest matching index.
  assign upd = idx_q == 4'd0 || (best_q != 8'd0 && (hit || dist < best_q));
`else
  perceptron_match u_match (.acc_i(acc_q), .idx_i(idx_q), .hit_o(hit));
`endif
  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  // Next-state logic; a frame ends on in_last or when the sample budget is used up
  always_comb begin
    state_d = accept ? ((in_last || last_cnt) ? CLASSIFY : ACCUM)
            : in_class ? (last_idx ? HOLD : CLASSIFY)
            : done ? IDLE : state_q;
  end
  // Handshake outputs decoded from the state
  always_comb begin
    in_ready    = state_q == IDLE || state_q == ACCUM;
    out_valid   = state_q == HOLD;
    out_class   = class_q;
    out_sum     = acc_q;
    out_overrun = ovr_q;
  end
  // Datapath next values: saturating accumulate, sample count, table scan
  always_comb begin
    acc_d   = accept ? acc_sat : done ? 8'd0 : acc_q;
    cnt_d   = accept ? cnt_q + CW'(1) : done ? '0 : cnt_q;
    ovr_d   = accept ? (!in_last && last_cnt) : done ? 1'b0 : ovr_q;
    idx_d   = in_class ? idx_q + 4'd1 : 4'd0;
`ifdef PERCEPTRON_NEAREST_EN
    class_d = in_class && upd ? idx_q : class_q;
    best_d  = in_class && upd ? dist : best_q;
`else
    class_d = !in_class ? class_q
            : (hit && (idx_q == 4'd0 || class_q == CLASS_NONE)) ? idx_q
            : idx_q == 4'd0 ? CLASS_NONE : class_q;
`endif
  end
  // Datapath registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc_q   <= 8'd0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      idx_q   <= 4'd0;
      class_q <= 4'd0;
`ifdef PERCEPTRON_NEAREST_EN
      best_q  <= 8'd0;
`endif
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      idx_q   <= idx_d;
      class_q <= class_d;
`ifdef PERCEPTRON_NEAREST_EN
      best_q  <= best_d;
`endif
    end
endmodule

// File: tb/tb_perceptron_sequencer.sv
// tb_perceptron_sequencer: scoreboard bench for perceptron_sequencer (honours PERCEPTRON_NEAREST_EN)
module tb_perceptron_sequencer;
  typedef struct {logic [3:0] cls; logic [7:0] sum; logic ovr;} exp_t;
  logic clk = 0, rst = 0, in_valid = 0, in_ready, in_last = 0;
  logic [2:0] in_edges = 0;
  logic [3:0] in_curves = 0;
  logic out_valid, out_ready = 0, out_overrun;
  logic [3:0] out_class;
  logic [7:0] out_sum;
  int tests = 0, fails = 0;
  int tgt[10] = '{32, 2, 20, 34, 6, 28, 40, 4, 64, 26};
  exp_t sb[$];
  int fe[$], fc[$];

  perceptron_sequencer dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_edges(in_edges), .in_curves(in_curves), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_class(out_class), .out_sum(out_sum), .out_overrun(out_overrun));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input bit use_last);
    exp_t e;
    int s = 0, n = fe.size(), bd = 0, d;
    for (int i = 0; i < n; i++) s = (s + fe[i] * 8 + fc[i] * 2 > 255) ? 255 : s + fe[i] * 8 + fc[i] * 2;
    e.sum = 8'(s);
    e.ovr = !use_last && n == 16;
    e.cls = 4'hF;
`ifdef PERCEPTRON_NEAREST_EN
    for (int i = 0; i < 10; i++) begin
      d = s > tgt[i] ? s - tgt[i] : tgt[i] - s;
      if (i == 0 || d < bd) begin bd = d; e.cls = 4'(i); end
    end
`else
    for (int i = 9; i >= 0; i--) if (tgt[i] == s) e.cls = 4'(i);
`endif
    sb.push_back(e);
    for (int i = 0; i < n; i++) begin
      in_valid = 1; in_edges = 3'(fe[i]); in_curves = 4'(fc[i]); in_last = use_last && i == n - 1;
      @(posedge clk); #1;
    end
    in_valid = 0; in_last = 0;
    fe.delete(); fc.delete();
  endtask

  task automatic collect(input int hold);
    exp_t e;
    int cyc = 1;
    while (!out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    chk("latency", cyc, 11);
    if (sb.size() == 0) begin chk("sb_empty", 1, 0); return; end
    e = sb.pop_front();
    chk("class", out_class, e.cls);
    chk("sum", out_sum, e.sum);
    chk("overrun", out_overrun, e.ovr);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1; in_edges = 3'd7; in_curves = 4'd15; in_last = 1;
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_class", out_class, e.cls);
      chk("hold_sum", out_sum, e.sum);
      chk("hold_ovr", out_overrun, e.ovr);
    end
    in_valid = 0; in_last = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("idle_ready", in_ready, 1);
    chk("idle_valid", out_valid, 0);
    chk("idle_sum", out_sum, 0);
  endtask

  initial begin
    rst = 1;
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_class", out_class, 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_ovr", out_overrun, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    fe = '{4}; fc = '{0}; send(1); collect(0);
    fe = '{2, 0}; fc = '{1, 1}; send(1); collect(0);
    fe = '{1}; fc = '{1}; send(1); collect(0);
    for (int i = 0; i < 16; i++) begin fe.push_back(7); fc.push_back(15); end
    send(0); collect(0);
    for (int i = 0; i < 16; i++) begin fe.push_back(0); fc.push_back(1); end
    send(1); collect(0);
    fe = '{3, 1}; fc = '{2, 3}; send(1); collect(5);
    fe = '{4}; fc = '{0}; send(1);
    void'(sb.pop_back());
    repeat (3) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_sum", out_sum, 0);
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      chk("mid_rst_valid", out_valid, 0);
    end
    fe = '{0}; fc = '{1}; send(1); collect(0);
    for (int r = 0; r < 6; r++) begin
      int n = $urandom_range(1, 16);
      for (int i = 0; i < n; i++) begin fe.push_back($urandom_range(0, 7)); fc.push_back($urandom_range(0, 15)); end
      send(1); collect($urandom_range(0, 2));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/perceptron_sequencer.md
PERCEPTRON_SEQUENCER -- requirements
Module: perceptron_sequencer

Interface
REQ-001 SHALL have parameter EDGE_SHIFT, default 3, meaning edge weight is 1<<EDGE_SHIFT.
REQ-002 SHALL have parameter CURVE_SHIFT, default 1, meaning curve weight is 1<<CURVE_SHIFT.
REQ-003 SHALL have parameter MAX_SAMPLES, default 16, meaning the maximum number of samples in one frame.
REQ-004 Ports: clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 Ports: rst  in  1  reset, asynchronous, active-high.
REQ-006 Ports: in_valid  in  1  a feature sample is present.
REQ-007 Ports: in_ready  out  1  the sequencer accepts the sample this cycle.
REQ-008 Ports: in_edges  in  3  edge count of the sample.
REQ-009 Ports: in_curves  in  4  curve count of the sample.
REQ-010 Ports: in_last  in  1  the sample is the final one of its frame.
REQ-011 Ports: out_valid  out  1  a classification result is held.
REQ-012 Ports: out_ready  in  1  the consumer accepts the result.
REQ-013 Ports: out_class  out  4  digit 0-9, or 4'hF when there is no match.
REQ-014 Ports: out_sum  out  8  final accumulated sum of the frame.
REQ-015 Ports: out_overrun  out  1  the frame was truncated at MAX_SAMPLES.

Function
REQ-016 SHALL implement FSM states IDLE, ACCUM, CLASSIFY and HOLD.
REQ-017 IDLE: in_ready=1; an accepted sample (in_valid&in_ready) loads acc and goes to ACCUM, or to CLASSIFY if in_last is set.
REQ-018 ACCUM: in_ready=1; each accepted sample adds (edges<<EDGE_SHIFT)+(curves<<CURVE_SHIFT) to acc.
REQ-019 acc SHALL be 8-bit and saturate at 255; it SHALL never wrap.
REQ-020 A sample counter SHALL count accepted samples. When the MAX_SAMPLES-th sample is accepted without in_last, the FSM SHALL go to CLASSIFY and set the overrun flag.
REQ-021 CLASSIFY: in_ready=0; the FSM SHALL compare acc with one table entry per cycle, index 0..9, for exactly 10 cycles, then go to HOLD.
REQ-022 An exact match SHALL record the lowest matching index. Without a match and without the macro, class=4'hF.
REQ-023 HOLD: out_valid=1, with out_class, out_sum and out_overrun stable. out_valid&out_ready SHALL return the FSM to IDLE on the next cycle, clearing acc, the counter and the flag.
REQ-024 HOLD: in_ready=0; in_valid SHALL be ignored.
REQ-025 Latency from acceptance of the last sample to out_valid SHALL be exactly 11 cycles.
REQ-026 The sample with in_last that is also the MAX_SAMPLES-th sample SHALL NOT set overrun.

Reset
REQ-027 rst SHALL immediately force IDLE, acc=0, count=0, out_valid=0, out_class=0, out_sum=0 and out_overrun=0. After reset, in_ready=1 (combinational from IDLE).
REQ-028 rst mid-frame or mid-CLASSIFY SHALL discard the partial frame; no result SHALL be emitted.

Configuration
REQ-029 Macro PERCEPTRON_NEAREST_EN defined: on no exact match, the class SHALL be the entry with minimum |acc-target|, ties to the lower index; 4'hF is never produced.
REQ-030 Macro PERCEPTRON_NEAREST_EN undefined: no-match SHALL yield 4'hF, and no distance logic SHALL be synthesized.

Structure
REQ-031 Package perceptron_pkg SHALL hold the state enum, the NUM_CLASSES=10 constant, the CLASS_NONE=4'hF constant and the target table: 32, 2, 20, 34, 6, 28, 40, 4, 64, 26 for classes 0..9.
REQ-032 Sub-module perceptron_match SHALL be combinational: it compares acc with one table entry and, under the macro, outputs the absolute distance.

Verification
REQ-033 One sample edges=4, curves=0, last=1 -> out_sum=32, out_class=0, out_valid exactly 11 cycles after acceptance.
REQ-034 Samples (2,1) then (0,1, last) -> out_sum=20, out_class=2.
REQ-035 Sample (1,1, last) -> out_sum=10; out_class=4'hF without the macro, 4 with it.
REQ-036 16 samples (7,15), none with last -> out_sum=255 (saturated), out_overrun=1, out_class=4'hF without the macro.
REQ-037 Hold out_ready=0 for 5 cycles in HOLD -> outputs stable, in_ready=0; then a ready pulse -> IDLE the next cycle with in_ready=1.
REQ-038 Assert rst during CLASSIFY -> out_valid stays 0, and the next frame (0,1, last) yields out_class=1.
